// File: rtl/conways_life_engine.sv
// Conway's Life engine: 8x16 toroidal grid, one row per cycle into a shadow
// buffer, committed atomically; step, free-running run mode and seed load.
//
// Ports:
//   ACLK, ARESETN            clock, async active-low reset
//   cfg_word0..cfg_word3     seed pattern, grid = {w3,w2,w1,w0}
//   load                     pulse: copy seed into grid, abort any generation
//   step                     pulse: compute one generation (ignored while busy)
//   run_en, period           run mode: auto-step after `period` idle cycles
//   grid_out                 current grid, bit r*16+c = (row r, col c)
//   gen_count                generations since last load (wraps)
//   busy                     generation in progress
//   gen_done                 one-cycle pulse after each commit
module conways_life_engine (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic [31:0]  cfg_word0,
  input  logic [31:0]  cfg_word1,
  input  logic [31:0]  cfg_word2,
  input  logic [31:0]  cfg_word3,
  input  logic         load,
  input  logic         step,
  input  logic         run_en,
  input  logic [15:0]  period,
  output logic [127:0] grid_out,
  output logic [15:0]  gen_count,
  output logic         busy,
  output logic         gen_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t         state;
  logic [127:0]   shadow;
  logic [2:0]     row;
  logic [15:0]    timer;

  logic [2:0]     row_m1;
  logic [2:0]     row_p1;
  logic [15:0]    r_prev;
  logic [15:0]    r_cur;
  logic [15:0]    r_next;
  logic [15:0]    next_row;
  logic [3:0]     nb;
  logic [3:0]     cl;
  logic [3:0]     cr;
  logic [3:0]     c4;
  logic           run_fire;

  // 3-bit row arithmetic wraps modulo 8 for free
  assign row_m1 = row - 3'd1;
  assign row_p1 = row + 3'd1;

  assign r_prev = grid_out[{row_m1, 4'b0000} +: 16];
  assign r_cur  = grid_out[{row,    4'b0000} +: 16];
  assign r_next = grid_out[{row_p1, 4'b0000} +: 16];

  assign run_fire = run_en && (timer == period);

  // B3/S23 for the row selected by `row`; column indices wrap modulo 16
  always_comb begin
    next_row = '0;
    nb       = '0;
    cl       = '0;
    cr       = '0;
    c4       = '0;
    for (int c = 0; c < 16; c++) begin
      c4 = 4'(c);
      cl = 4'(c + 15);
      cr = 4'(c + 1);
      nb = {3'b000, r_prev[cl]} + {3'b000, r_prev[c4]}
         + {3'b000, r_prev[cr]} + {3'b000, r_cur[cl]}
         + {3'b000, r_cur[cr]}  + {3'b000, r_next[cl]}
         + {3'b000, r_next[c4]} + {3'b000, r_next[cr]};
      next_row[c] = (nb == 4'd3) | (r_cur[c4] & (nb == 4'd2));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      grid_out  <= '0;
      shadow    <= '0;
      gen_count <= '0;
      busy      <= 1'b0;
      gen_done  <= 1'b0;
      timer     <= '0;
      row       <= '0;
    end else begin
      gen_done <= 1'b0;
      if (load) begin
        grid_out  <= {cfg_word3, cfg_word2, cfg_word1, cfg_word0};
        shadow    <= '0;
        gen_count <= '0;
        timer     <= '0;
        row       <= '0;
        busy      <= 1'b0;
        state     <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (step || run_fire) begin
              state <= COMPUTE;
              busy  <= 1'b1;
              row   <= '0;
              timer <= '0;
            end else if (run_en) begin
              timer <= timer + 16'd1;
            end else begin
              timer <= '0;
            end
          end
          COMPUTE: begin
            shadow[{row, 4'b0000} +: 16] <= next_row;
            row <= row + 3'd1;
            if (row == 3'd7)
              state <= COMMIT;
          end
          COMMIT: begin
            grid_out  <= shadow;
            gen_count <= gen_count + 16'd1;
            gen_done  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conways_life_engine.sv
// Testbench for conways_life_engine: directed scenarios plus random
// seeds checked against a cell-by-cell Life model.
module tb_conways_life_engine;

  logic         tb_ACLK = 1'b0;
  logic         tb_ARESETN;
  logic [31:0]  cfg_word0, cfg_word1, cfg_word2, cfg_word3;
  logic         load, step, run_en;
  logic [15:0]  period;
  logic [127:0] grid_out;
  logic [15:0]  gen_count;
  logic         busy, gen_done;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] model;
  logic [15:0]  exp_cnt;

  conways_life_engine dut (
    .ACLK      (tb_ACLK),
    .ARESETN   (tb_ARESETN),
    .cfg_word0 (cfg_word0),
    .cfg_word1 (cfg_word1),
    .cfg_word2 (cfg_word2),
    .cfg_word3 (cfg_word3),
    .load      (load),
    .step      (step),
    .run_en    (run_en),
    .period    (period),
    .grid_out  (grid_out),
    .gen_count (gen_count),
    .busy      (busy),
    .gen_done  (gen_done)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Life rule straight from the definition: count the 8 wrapped neighbours
  function automatic logic [127:0] life_next(input logic [127:0] g);
    logic [127:0] o;
    int n;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(g[((r + dr + 8) % 8) * 16 + (c + dc + 16) % 16]);
        o[r * 16 + c] = (n == 3) || (g[r * 16 + c] && n == 2);
      end
    return o;
  endfunction

  task automatic do_load(input logic [127:0] s);
    @(negedge tb_ACLK);
    {cfg_word3, cfg_word2, cfg_word1, cfg_word0} = s;
    load = 1'b1;
    @(negedge tb_ACLK);
    load = 1'b0;
    model   = s;
    exp_cnt = '0;
  endtask

  // Step and wait (bounded) for gen_done, then compare against the model
  task automatic run_step(input string tag);
    int n;
    @(negedge tb_ACLK);
    step = 1'b1;
    @(negedge tb_ACLK);
    step = 1'b0;
    n = 0;
    while (!gen_done && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    model   = life_next(model);
    exp_cnt = exp_cnt + 16'd1;
    check({tag, "_done"}, gen_done, 1'b1);
    check({tag, "_grid"}, grid_out, model);
    check({tag, "_cnt"}, gen_count, exp_cnt);
  endtask

  // Step with cycle-exact checks of busy, gen_done and grid stability
  task automatic timed_step(input string tag, input logic [127:0] exp_grid);
    logic [127:0] old;
    int bad;
    old = grid_out;
    bad = 0;
    @(negedge tb_ACLK);
    step = 1'b1;
    @(negedge tb_ACLK);
    step = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!(busy === 1'b1 && gen_done === 1'b0 && grid_out === old))
        bad++;
      @(negedge tb_ACLK);
    end
    check({tag, "_busy_window"}, 128'(bad), 128'd0);
    exp_cnt = exp_cnt + 16'd1;
    check({tag, "_grid"}, grid_out, exp_grid);
    check({tag, "_cnt"}, gen_count, exp_cnt);
    check({tag, "_done_hi"}, {busy, gen_done}, 2'b01);
    @(negedge tb_ACLK);
    check({tag, "_done_lo"}, gen_done, 1'b0);
  endtask

  localparam logic [127:0] BLINK_H = {32'h0, 32'h0, 32'h00700000, 32'h0};
  localparam logic [127:0] BLINK_V = {32'h0, 32'h00000020, 32'h00200020, 32'h0};

  initial begin
    int p[3];
    int np, cyc, seen, nsteps;
    tb_ARESETN = 1'b0;
    {cfg_word3, cfg_word2, cfg_word1, cfg_word0} = '0;
    load = 0; step = 0; run_en = 0; period = '0;
    model = '0; exp_cnt = '0;

    repeat (3) @(negedge tb_ACLK);
    check("rst_grid", grid_out, '0);
    check("rst_flags", {gen_count, busy, gen_done}, '0);
    tb_ARESETN = 1'b1;

    // blinker, two generations
    do_load(BLINK_H);
    check("blink_load", grid_out, BLINK_H);
    timed_step("blink1", BLINK_V);
    timed_step("blink2", BLINK_H);

    // block still life
    do_load({96'h0, 32'h00030003});
    for (int i = 0; i < 5; i++) run_step("block");
    check("block_same", grid_out, {96'h0, 32'h00030003});
    check("block_cnt", gen_count, 16'd5);

    // toroidal wrap
    do_load({96'h0, 32'h00008003});
    run_step("wrap");
    check("wrap_const", grid_out,
          {32'h00010000, 32'h0, 32'h0, 32'h00010001});

    // abort by load on the 4th busy cycle
    do_load(BLINK_H);
    @(negedge tb_ACLK);
    step = 1'b1;
    @(negedge tb_ACLK);
    step = 1'b0;
    repeat (2) @(negedge tb_ACLK);
    {cfg_word3, cfg_word2, cfg_word1, cfg_word0} = {96'h0, 32'h1};
    load = 1'b1;
    @(negedge tb_ACLK);
    load = 1'b0;
    model = {96'h0, 32'h1};
    exp_cnt = '0;
    check("abort_busy", busy, 1'b0);
    check("abort_grid", grid_out, {96'h0, 32'h1});
    check("abort_cnt", gen_count, 16'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (gen_done) seen++;
      @(negedge tb_ACLK);
    end
    check("abort_no_done", 128'(seen), 128'd0);
    check("abort_hold", grid_out, {96'h0, 32'h1});

    // step while busy is dropped
    @(negedge tb_ACLK);
    step = 1'b1;
    @(negedge tb_ACLK);
    step = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    step = 1'b1;
    @(negedge tb_ACLK);
    step = 1'b0;
    repeat (20) @(negedge tb_ACLK);
    check("busy_step_cnt", gen_count, 16'd1);
    check("busy_step_grid", grid_out, life_next({96'h0, 32'h1}));

    // run mode, period 3
    do_load(BLINK_H);
    period = 16'd3;
    run_en = 1'b1;
    np = 0;
    cyc = 0;
    while (np < 3 && cyc < 100) begin
      @(negedge tb_ACLK);
      cyc++;
      if (gen_done) begin
        p[np] = cyc;
        np++;
      end
    end
    run_en = 1'b0;
    check("run_pulses", 128'(np), 128'd3);
    if (np == 3) begin
      check("run_gap1", 128'(p[1] - p[0]), 128'd13);
      check("run_gap2", 128'(p[2] - p[1]), 128'd13);
    end
    repeat (15) @(negedge tb_ACLK);
    check("run_cnt", gen_count, 16'd3);
    check("run_grid", grid_out, BLINK_V);

    // run mode, period 0: back-to-back generations
    do_load(BLINK_H);
    period = 16'd0;
    run_en = 1'b1;
    np = 0;
    cyc = 0;
    while (np < 2 && cyc < 60) begin
      @(negedge tb_ACLK);
      cyc++;
      if (gen_done) begin
        p[np] = cyc;
        np++;
      end
    end
    run_en = 1'b0;
    check("run0_pulses", 128'(np), 128'd2);
    if (np == 2) check("run0_gap", 128'(p[1] - p[0]), 128'd10);
    repeat (12) @(negedge tb_ACLK);

    // random seeds against the model
    for (int t = 0; t < 16; t++) begin
      do_load({$urandom, $urandom, $urandom, $urandom});
      check("rand_load", grid_out, model);
      nsteps = int'($urandom_range(1, 3));
      for (int s = 0; s < nsteps; s++) run_step("rand");
    end

    // reset mid-compute
    do_load(BLINK_H);
    @(negedge tb_ACLK);
    step = 1'b1;
    @(negedge tb_ACLK);
    step = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    #2 tb_ARESETN = 1'b0;
    #1;
    check("arst_grid", grid_out, '0);
    check("arst_flags", {gen_count, busy, gen_done}, '0);
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge tb_ACLK);
      if (gen_done || busy || grid_out != '0) seen++;
    end
    check("arst_no_commit", 128'(seen), 128'd0);

    // load accepted on first edge after release
    tb_ARESETN = 1'b0;
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1;
    {cfg_word3, cfg_word2, cfg_word1, cfg_word0} = BLINK_V;
    load = 1'b1;
    @(negedge tb_ACLK);
    load = 1'b0;
    check("first_load", grid_out, BLINK_V);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conways_life_engine.md
CONWAYS_LIFE_ENGINE -- requirements
Module: conways_life_engine

Interface
REQ-001 SHALL have one clock ACLK; reset ARESETN is asynchronous and active-low.
REQ-002 SHALL have the port list below, clock and reset first:
- ACLK  in  1  system clock.
- ARESETN  in  1  async active-low reset.
- cfg_word0..cfg_word3  in  32 each  seed pattern, driven from AXI-Lite slave registers 0..3.
- load  in  1  single-cycle pulse: copy seed into grid.
- step  in  1  single-cycle pulse: compute one generation.
- run_en  in  1  level: free-running generation mode.
- period  in  16  idle cycles between auto-steps in run mode.
- grid_out  out  128  current grid; bit r*16+c = cell (row r, col c).
- gen_count  out  16  generations since last load.
- busy  out  1  generation in progress.
- gen_done  out  1  one-cycle pulse after each commit.

Function
REQ-003 Grid SHALL be 8 rows x 16 cols, toroidal: row and column indices wrap modulo 8 and 16.
REQ-004 Load SHALL map grid_out[127:0] = {cfg_word3, cfg_word2, cfg_word1, cfg_word0}.
REQ-005 Next state SHALL follow B3/S23: live cell with 2 or 3 live neighbours survives; dead cell with exactly 3 becomes live; all others die. Neighbour count is 4 bits, range 0..8.
REQ-006 FSM SHALL have states IDLE, COMPUTE, COMMIT.
REQ-007 IDLE -> COMPUTE SHALL occur on a step pulse or a run-mode trigger; row index resets to 0.
REQ-008 COMPUTE SHALL evaluate one row per cycle, rows 0..7, writing a shadow buffer; the current grid is unchanged during COMPUTE.
REQ-009 COMPUTE SHALL go to COMMIT after row 7.
REQ-010 COMMIT SHALL copy shadow to grid, increment gen_count, and return to IDLE.
REQ-011 Latency: step sampled at edge T; rows computed on edges T+1..T+8; grid_out and gen_count update on edge T+9; gen_done is high for exactly the cycle following T+9.
REQ-012 busy SHALL be high in COMPUTE and COMMIT and low in IDLE.
REQ-013 A step pulse while busy SHALL be ignored and not queued.
REQ-014 load SHALL take priority over step and run trigger in every state.
REQ-015 load while busy SHALL abort the generation, discard the shadow buffer, and return to IDLE.
REQ-016 On load: grid loaded, gen_count = 0, gen_done not asserted, run timer cleared.
REQ-017 Run mode, with run_en = 1 in IDLE: the timer increments each idle cycle; a trigger fires when timer == period, then the timer clears.
- period = 0 SHALL trigger on every idle cycle.
- run_en = 0 SHALL hold the timer at 0.
REQ-018 gen_count SHALL wrap 0xFFFF -> 0x0000 without a flag.
REQ-019 step and run trigger in the same cycle SHALL start exactly one generation.

Reset
REQ-020 On ARESETN low, all of the following SHALL take effect immediately:
- grid_out = 0, shadow = 0, gen_count = 0.
- busy = 0, gen_done = 0.
- state = IDLE, timer = 0, row index = 0.
REQ-021 Reset asserted mid-generation SHALL abandon the generation; no partial commit is visible after release.
REQ-022 First load or step SHALL be accepted on the first rising edge after ARESETN deasserts.

Verification
REQ-023 Blinker:
- load word1 = 0x00700000, others 0; step.
- -> 9 cycles later word1 = 0x00200020, word2 = 0x00000020, gen_count = 1, one gen_done pulse.
- Second step -> original pattern, gen_count = 2.
REQ-024 Still life: load word0 = 0x00030003; 5 steps -> grid unchanged, gen_count = 5.
REQ-025 Wrap:
- load word0 = 0x00008003; step.
- -> word0 = 0x00010001, word3 = 0x00010000, others 0.
REQ-026 Abort:
- step, then load (word0 = 0x00000001) on the 4th busy cycle.
- -> busy low next cycle; grid = 0x...0001; gen_count = 0; no gen_done pulse.
- A step during busy SHALL leave gen_count advanced by one only.
REQ-027 Run mode:
- blinker loaded, period = 3, run_en = 1 for 3 generations.
- -> gen_done pulses spaced 13 cycles apart (9 busy + 4 idle); gen_count = 3.
- Reset asserted mid-COMPUTE -> all outputs 0.
